// File: rtl/norm_accum_pipe.sv
// norm_accum_pipe
//   Pipelined reduction engine over an internal DEPTH-entry signed array.
//   One array read per cycle reduces a[start..end-1] into a signed
//   accumulator, using one of three modes:
//     0 (and 3) : sum of x*x
//     1         : sum of |x|
//     2         : max(acc, |x|)
//   Sum modes saturate at the largest positive accumulator value and raise
//   a sticky overflow flag. The host can take over the array port on any
//   cycle; the engine then skips its issue for that cycle.
//
// Ports
//   clk                  in  clock, all logic on posedge
//   r_enable             in  sync active-high reset; latches init_* and arms a run
//   init_start           in  first index (inclusive)
//   init_end             in  last index (exclusive), clamped to DEPTH
//   init_acc             in  signed starting accumulator
//   init_mode            in  reduction mode
//   controlArr           in  host owns the array port this cycle
//   controlArrWEnable_a  in  host write strobe (only honoured with controlArr)
//   controlArrAddr_a     in  host address
//   controlArrWData_a    in  host write data
//   controlArrRData_a    out host read data, one cycle after the address
//   w_enable             out result valid, held until the next r_enable
//   result               out final accumulator
//   overflow             out sticky saturation flag for this run
module norm_accum_pipe #(
  parameter int DATA_W = 27,
  parameter int ACC_W  = 64,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     r_enable,
  input  logic [ADDR_W-1:0]        init_start,
  input  logic [ADDR_W:0]          init_end,
  input  logic signed [ACC_W-1:0]  init_acc,
  input  logic [1:0]               init_mode,
  input  logic                     controlArr,
  input  logic                     controlArrWEnable_a,
  input  logic [ADDR_W-1:0]        controlArrAddr_a,
  input  logic signed [DATA_W-1:0] controlArrWData_a,
  output logic signed [DATA_W-1:0] controlArrRData_a,
  output logic                     w_enable,
  output logic signed [ACC_W-1:0]  result,
  output logic                     overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Full-width signed square; operands are widened first so the product
  // is exact for every DATA_W input.
  function automatic logic signed [2*DATA_W-1:0] square(input logic signed [DATA_W-1:0] x);
    logic signed [2*DATA_W-1:0] xe;
    xe = (2*DATA_W)'(x);
    return xe * xe;
  endfunction

  // One extra bit so the most negative input has an exact magnitude.
  function automatic logic signed [DATA_W:0] abs_ext(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] xe;
    xe = (DATA_W+1)'(x);
    return x[DATA_W-1] ? -xe : xe;
  endfunction

  // Returns {saturated, value}. The added term is never negative, so only
  // the positive limit can be crossed.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (s > (ACC_W+1)'(ACC_MAX)) begin
      return {1'b1, ACC_MAX};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  logic signed [DATA_W-1:0] mem [DEPTH];

  state_t                   state_q, state_d;
  logic [ADDR_W:0]          idx_q;
  logic [ADDR_W:0]          end_q;
  logic [1:0]               mode_q;
  logic                     vld_p1_q, vld_p2_q, vld_p3_q;
  logic                     w_enable_q;
  logic                     overflow_q, overflow_d;

  logic [ADDR_W-1:0]        addr_p1_q;
  logic signed [DATA_W-1:0] data_p2_q;
  logic signed [ACC_W-1:0]  term_p3_q, term_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  result_q;

  logic                     running;
  logic                     more;
  logic                     issue;
  logic                     done_set;
  logic signed [DATA_W-1:0] rd_data;
  logic                     add_sat;
  logic signed [ACC_W-1:0]  add_val;

  // IDLE is the first cycle of a run: issuing starts there, which gives
  // the N+4 cycle latency from the first cycle with r_enable low.
  assign running = (state_q == S_IDLE) || (state_q == S_RUN);
  assign more    = idx_q < end_q;
  assign issue   = running && more && !controlArr;

  // E0 -> E1: registered address, asynchronous array read.
  assign rd_data = ({1'b0, addr_p1_q} < DEPTH_C) ? mem[addr_p1_q] : '0;

  // E2 -> E3: element operation.
  always_comb begin
    term_d = ACC_W'(square(data_p2_q));
    if (mode_q == 2'd1 || mode_q == 2'd2) begin
      term_d = ACC_W'(abs_ext(data_p2_q));
    end
  end

  // E3 -> E4: accumulate.
  always_comb begin
    {add_sat, add_val} = sat_add(acc_q, term_p3_q);
    acc_d      = acc_q;
    overflow_d = overflow_q;
    if (vld_p3_q) begin
      if (mode_q == 2'd2) begin
        acc_d = (term_p3_q > acc_q) ? term_p3_q : acc_q;
      end else begin
        acc_d      = add_val;
        overflow_d = overflow_q | add_sat;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: state_d = more ? S_RUN : S_DRAIN;
      S_DRAIN: begin
        if (!(vld_p1_q || vld_p2_q || vld_p3_q)) begin
          state_d  = S_DONE;
          done_set = 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_enable) begin
      state_q    <= S_IDLE;
      idx_q      <= {1'b0, init_start};
      end_q      <= (init_end > DEPTH_C) ? DEPTH_C : init_end;
      mode_q     <= init_mode;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      vld_p3_q   <= 1'b0;
      w_enable_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (issue) begin
        idx_q <= idx_q + (ADDR_W+1)'(1);
      end
      vld_p1_q   <= issue;
      vld_p2_q   <= vld_p1_q;
      vld_p3_q   <= vld_p2_q;
      overflow_q <= overflow_d;
      if (done_set) begin
        w_enable_q <= 1'b1;
      end
    end
  end

  // The address register is shared with the host; the engine's read from
  // the previous cycle is already captured, so a host cycle never corrupts it.
  always_ff @(posedge clk) begin
    addr_p1_q <= controlArr ? controlArrAddr_a : idx_q[ADDR_W-1:0];
    data_p2_q <= rd_data;
    term_p3_q <= term_d;
    acc_q     <= r_enable ? init_acc : acc_d;
    if (!r_enable && done_set) begin
      result_q <= acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (controlArr && controlArrWEnable_a && ({1'b0, controlArrAddr_a} < DEPTH_C)) begin
      mem[controlArrAddr_a] <= controlArrWData_a;
    end
  end

  assign controlArrRData_a = rd_data;
  assign w_enable          = w_enable_q;
  assign result            = result_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_norm_accum_pipe.sv
module tb_norm_accum_pipe;
  localparam int DATA_W = 27;
  localparam int ACC_W  = 64;
  localparam int DEPTH  = 1000;
  localparam int ADDR_W = 10;
  localparam int PLEN   = 4096;

  logic                     clk = 1'b0;
  logic                     r_enable;
  logic [ADDR_W-1:0]        init_start;
  logic [ADDR_W:0]          init_end;
  logic signed [ACC_W-1:0]  init_acc;
  logic [1:0]               init_mode;
  logic                     controlArr;
  logic                     controlArrWEnable_a;
  logic [ADDR_W-1:0]        controlArrAddr_a;
  logic signed [DATA_W-1:0] controlArrWData_a;
  logic signed [DATA_W-1:0] controlArrRData_a;
  logic                     w_enable;
  logic signed [ACC_W-1:0]  result;
  logic                     overflow;

  always #5 clk = ~clk;

  norm_accum_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .r_enable            (r_enable),
    .init_start          (init_start),
    .init_end            (init_end),
    .init_acc            (init_acc),
    .init_mode           (init_mode),
    .controlArr          (controlArr),
    .controlArrWEnable_a (controlArrWEnable_a),
    .controlArrAddr_a    (controlArrAddr_a),
    .controlArrWData_a   (controlArrWData_a),
    .controlArrRData_a   (controlArrRData_a),
    .w_enable            (w_enable),
    .result              (result),
    .overflow            (overflow)
  );

  typedef struct {
    longint res;
    bit     ovf;
    int     lat;
    int     start;
  } exp_t;

  exp_t   q[$];
  longint mm[DEPTH];
  bit     stl[PLEN];
  int     haddr[PLEN];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference reduction straight from the mode definitions.
  function automatic void model(input int s, input int e, input longint acc0, input int mode,
                                output longint res, output bit ovf);
    logic signed [127:0] wide;
    logic signed [127:0] lim;
    longint acc, x, ax, term;
    int ee;
    lim = 128'sh7FFF_FFFF_FFFF_FFFF;
    acc = acc0;
    ovf = 1'b0;
    ee  = (e > DEPTH) ? DEPTH : e;
    for (int i = s; i < ee; i++) begin
      x  = mm[i];
      ax = (x < 0) ? -x : x;
      if (mode == 2) begin
        acc = (ax > acc) ? ax : acc;
      end else begin
        term = (mode == 1) ? ax : x * x;
        wide = 128'(acc) + 128'(term);
        if (wide > lim) begin
          acc = 64'sh7FFF_FFFF_FFFF_FFFF;
          ovf = 1'b1;
        end else begin
          acc = longint'(wide);
        end
      end
    end
    res = acc;
  endfunction

  task automatic check1(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  task automatic host_write(input int a, input longint v);
    @(posedge clk); #1;
    controlArr          = 1'b1;
    controlArrWEnable_a = 1'b1;
    controlArrAddr_a    = ADDR_W'(a);
    controlArrWData_a   = DATA_W'(v);
    mm[a]               = v;
  endtask

  task automatic host_idle();
    @(posedge clk); #1;
    controlArr          = 1'b0;
    controlArrWEnable_a = 1'b0;
  endtask

  task automatic clear_stalls();
    for (int k = 0; k < PLEN; k++) begin
      stl[k]   = 1'b0;
      haddr[k] = 0;
    end
  endtask

  task automatic random_stalls();
    for (int k = 0; k < PLEN; k++) begin
      stl[k]   = ($urandom_range(0, 3) == 0);
      haddr[k] = $urandom_range(0, DEPTH - 1);
    end
  endtask

  // One run: configure, push the expectation, drive the host pattern and
  // wait (bounded) for the monitor to consume it. abort_at > 0 leaves the
  // run mid-flight so the next call's r_enable cancels it.
  task automatic run(input int s, input int e, input longint acc0, input int mode,
                     input int abort_at);
    longint r;
    bit o;
    int ee, n, lat, zeros;
    bit finished;
    logic signed [DATA_W-1:0] ev;
    model(s, e, acc0, mode, r, o);
    ee = (e > DEPTH) ? DEPTH : e;
    n  = (ee > s) ? ee - s : 0;
    lat = 2;
    if (n > 0) begin
      zeros = 0;
      lat   = -1;
      for (int k = 0; k < PLEN && lat < 0; k++) begin
        if (!stl[k]) begin
          zeros++;
          if (zeros == n) lat = k + 5;
        end
      end
    end
    @(posedge clk); #1;
    r_enable            = 1'b1;
    init_start          = ADDR_W'(s);
    init_end            = (ADDR_W+1)'(e);
    init_acc            = acc0;
    init_mode           = 2'(mode);
    controlArr          = 1'b0;
    controlArrWEnable_a = 1'b0;
    @(posedge clk); #1;
    r_enable = 1'b0;
    q.push_back('{r, o, lat, cyc});
    check1("reset_w_enable", longint'(w_enable), 0);
    check1("reset_overflow", longint'(overflow), 0);
    controlArr       = stl[0];
    controlArrAddr_a = ADDR_W'(haddr[0]);
    finished = 1'b0;
    for (int k = 1; k < 6000; k++) begin
      @(posedge clk); #1;
      if (k < PLEN && stl[k-1]) begin
        ev = DATA_W'(mm[haddr[k-1]]);
        check1("host_readback", longint'(controlArrRData_a), longint'(ev));
      end
      if (abort_at > 0 && k == abort_at) begin
        void'(q.pop_back());
        controlArr = 1'b0;
        return;
      end
      controlArr       = (k < PLEN) ? stl[k] : 1'b0;
      controlArrAddr_a = ADDR_W'((k < PLEN) ? haddr[k] : 0);
      if (q.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    controlArr = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL run_timeout start %0d end %0d mode %0d no w_enable", s, e, mode);
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    check1("w_enable_held", longint'(w_enable), 1);
  endtask

  // Monitor: compares every rising w_enable against the oldest expectation.
  initial begin : monitor
    exp_t ex;
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (w_enable === 1'b1 && !prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_w_enable got result %0d want no completion", result);
        end else begin
          ex = q.pop_front();
          check1("result", result, ex.res);
          check1("overflow", longint'(overflow), longint'(ex.ovf));
          check1("latency", longint'(cyc - ex.start), longint'(ex.lat));
        end
      end
      prev = (w_enable === 1'b1);
    end
  end

  initial begin
    int s, len, mode, v;
    longint acc0;
    r_enable            = 1'b1;
    init_start          = '0;
    init_end            = '0;
    init_acc            = '0;
    init_mode           = '0;
    controlArr          = 1'b0;
    controlArrWEnable_a = 1'b0;
    controlArrAddr_a    = '0;
    controlArrWData_a   = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < DEPTH; i++) host_write(i, longint'(i));
    host_idle();

    // Full-array sum of squares, then the same with a 5-cycle host window.
    clear_stalls();
    run(0, 1000, 0, 0, 0);
    for (int k = 100; k < 105; k++) stl[k] = 1'b1;
    run(0, 1000, 0, 0, 0);

    // Abort mid-run, then a short run.
    clear_stalls();
    run(0, 1000, 0, 0, 500);
    run(0, 2, 0, 0, 0);

    // Abs and max modes including the most negative element.
    host_write(5, -3);
    host_write(6, 4);
    host_write(7, -(longint'(1) << 26));
    host_idle();
    run(5, 8, 10, 1, 0);
    run(5, 8, 0, 2, 0);

    // Empty ranges.
    run(7, 7, 12345, 0, 0);
    run(9, 3, -77, 1, 0);

    // Saturation, end clamp, mode 3.
    host_write(0, 4);
    host_idle();
    run(0, 1, 64'sh7FFF_FFFF_FFFF_FFF6, 0, 0);
    run(995, 1023, 0, 1, 0);
    run(1, 4, 0, 3, 0);

    // Randomized runs.
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < 12; w++) begin
        v = $urandom;
        v = v >>> 5;
        if ($urandom_range(0, 7) == 0) v = -(1 << 26);
        host_write($urandom_range(0, DEPTH - 1), longint'(v));
      end
      host_idle();
      random_stalls();
      s    = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(0, 150);
      mode = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       acc0 = longint'($urandom_range(0, 2000)) - 1000;
        1:       acc0 = 64'sh7FFF_FFFF_FFFF_FFFF - longint'($urandom_range(0, 1 << 30));
        default: acc0 = longint'({$urandom, $urandom});
      endcase
      run(s, s + len, acc0, mode, 0);
    end

    repeat (20) @(posedge clk);
    #1;
    check1("pending_expectations", longint'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
